// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, ALU codes,
// step states and the packed strobe bundle driven by the decoder.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } stepStateT;

  typedef struct packed {
    logic pcOut;
    logic incPc;
    logic pcIn;
    logic marIn;
    logic mdrIn;
    logic mdrOut;
    logic irIn;
    logic yIn;
    logic zIn;
    logic zloOut;
    logic cSignOut;
    logic gra;
    logic grb;
    logic grc;
    logic rIn;
    logic rOut;
    logic baOut;
    logic memRead;
    logic memWrite;
  } strobesT;

  // Immediate-form opcodes map onto the ALU operation of their register form.
  function automatic logic [4:0] immAluOp(input logic [4:0] opcode);
    case (opcode)
      OP_ANDI: immAluOp = ALU_AND;
      OP_ORI:  immAluOp = ALU_OR;
      default: immAluOp = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired step sequencer for the Mini SRC datapath.
//
// state | meaning
// T0    | fetch: PC onto bus, load MAR, Z <= PC+1
// T1    | fetch: PC <= Z, memory read into MDR
// T2    | fetch: MDR into IR
// T3    | execute: first operand (or nop / halt / illegal decision)
// T4    | execute: ALU operation into Z
// T5    | execute: writeback, or effective address into MAR for ld/st
// T6    | ld: memory read; st: source register into MDR
// T7    | ld: MDR into Ra; st: memory write
// HALT  | stopped, all strobes low, leaves only on clear
module control_unit
  import cpu_pkg::*;
#(
  parameter bit RESET_PC_LOAD = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        CSignout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic [4:0]  aluControl,
  output logic        run,
  output logic        illegal
);

  stepStateT  state, nextState;
  logic       illegalQ;
  logic       setIllegal;
  logic       pcLoadPending;
  strobesT    sb;
  logic [4:0] opcode;
  logic       unusedIrBits;

  assign opcode       = IR[31:27];
  assign unusedIrBits = ^IR[26:0];

  // State, sticky illegal flag and the optional post-reset PC load pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= T0;
      illegalQ      <= 1'b0;
      pcLoadPending <= RESET_PC_LOAD;
    end else begin
      state         <= nextState;
      illegalQ      <= illegalQ | setIllegal;
      pcLoadPending <= 1'b0;
    end
  end

  // Next-state and strobe decode from the step state and the instruction.
  // clear forces the idle strobe set so nothing fires in the reset cycle;
  // stop in T0 suppresses the fetch so the PC is never incremented.
  always_comb begin
    sb         = '0;
    aluControl = ALU_ADD;
    run        = 1'b1;
    setIllegal = 1'b0;
    nextState  = state;

    if (pcLoadPending) begin
      sb.pcIn   = 1'b1;
      nextState = T0;
    end else begin
      case (state)
        T0: begin
          if (stop) begin
            nextState = HALT;
          end else begin
            sb.pcOut  = 1'b1;
            sb.marIn  = 1'b1;
            sb.incPc  = 1'b1;
            sb.zIn    = 1'b1;
            nextState = T1;
          end
        end
        T1: begin
          sb.zloOut  = 1'b1;
          sb.pcIn    = 1'b1;
          sb.memRead = 1'b1;
          sb.mdrIn   = 1'b1;
          nextState  = T2;
        end
        T2: begin
          sb.mdrOut = 1'b1;
          sb.irIn   = 1'b1;
          nextState = T3;
        end
        T3: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
              sb.grb    = 1'b1;
              sb.rOut   = 1'b1;
              sb.yIn    = 1'b1;
              nextState = T4;
            end
            OP_LDI, OP_LD, OP_ST: begin
              sb.grb    = 1'b1;
              sb.baOut  = 1'b1;
              sb.yIn    = 1'b1;
              nextState = T4;
            end
            OP_NOP:  nextState = T0;
            OP_HALT: nextState = HALT;
            default: begin
              nextState  = HALT;
              setIllegal = 1'b1;
            end
          endcase
        end
        T4: begin
          nextState = T5;
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              sb.grc     = 1'b1;
              sb.rOut    = 1'b1;
              sb.zIn     = 1'b1;
              aluControl = opcode;
            end
            default: begin
              sb.cSignOut = 1'b1;
              sb.zIn      = 1'b1;
              aluControl  = immAluOp(opcode);
            end
          endcase
        end
        T5: begin
          sb.zloOut = 1'b1;
          if (opcode == OP_LD || opcode == OP_ST) begin
            sb.marIn  = 1'b1;
            nextState = T6;
          end else begin
            sb.gra    = 1'b1;
            sb.rIn    = 1'b1;
            nextState = T0;
          end
        end
        T6: begin
          sb.mdrIn  = 1'b1;
          nextState = T7;
          if (opcode == OP_ST) begin
            sb.gra  = 1'b1;
            sb.rOut = 1'b1;
          end else begin
            sb.memRead = 1'b1;
          end
        end
        T7: begin
          nextState = T0;
          if (opcode == OP_ST) begin
            sb.memWrite = 1'b1;
          end else begin
            sb.mdrOut = 1'b1;
            sb.gra    = 1'b1;
            sb.rIn    = 1'b1;
          end
        end
        HALT: begin
          run       = 1'b0;
          nextState = HALT;
        end
        default: nextState = T0;
      endcase
    end

    if (clear) begin
      sb         = '0;
      aluControl = ALU_ADD;
      run        = 1'b1;
      nextState  = T0;
      setIllegal = 1'b0;
    end
  end

  assign illegal  = illegalQ & ~clear;

  assign PCout    = sb.pcOut;
  assign IncPC    = sb.incPc;
  assign PCin     = sb.pcIn;
  assign MARin    = sb.marIn;
  assign MDRin    = sb.mdrIn;
  assign MDRout   = sb.mdrOut;
  assign IRin     = sb.irIn;
  assign Yin      = sb.yIn;
  assign Zin      = sb.zIn;
  assign ZLOout   = sb.zloOut;
  assign CSignout = sb.cSignOut;
  assign Gra      = sb.gra;
  assign Grb      = sb.grb;
  assign Grc      = sb.grc;
  assign Rin      = sb.rIn;
  assign Rout     = sb.rOut;
  assign BAout    = sb.baOut;
  assign read     = sb.memRead;
  assign write    = sb.memWrite;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected output
// vector for every cycle it drives, the monitor pops and compares on negedge.
module tb_control_unit;
  import cpu_pkg::*;

  logic clock, clear, stop;
  logic [31:0] IR;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout, CSignout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, run, illegal;
  logic [4:0] aluControl;

  control_unit #(.RESET_PC_LOAD(1'b0)) dut (
    .clock(clock), .clear(clear), .IR(IR), .stop(stop),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout),
    .CSignout(CSignout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .read(read), .write(write),
    .aluControl(aluControl), .run(run), .illegal(illegal)
  );

  localparam logic [18:0] S_PCOUT  = 19'd1 << 18;
  localparam logic [18:0] S_INCPC  = 19'd1 << 17;
  localparam logic [18:0] S_PCIN   = 19'd1 << 16;
  localparam logic [18:0] S_MARIN  = 19'd1 << 15;
  localparam logic [18:0] S_MDRIN  = 19'd1 << 14;
  localparam logic [18:0] S_MDROUT = 19'd1 << 13;
  localparam logic [18:0] S_IRIN   = 19'd1 << 12;
  localparam logic [18:0] S_YIN    = 19'd1 << 11;
  localparam logic [18:0] S_ZIN    = 19'd1 << 10;
  localparam logic [18:0] S_ZLOOUT = 19'd1 << 9;
  localparam logic [18:0] S_CSIGN  = 19'd1 << 8;
  localparam logic [18:0] S_GRA    = 19'd1 << 7;
  localparam logic [18:0] S_GRB    = 19'd1 << 6;
  localparam logic [18:0] S_GRC    = 19'd1 << 5;
  localparam logic [18:0] S_RIN    = 19'd1 << 4;
  localparam logic [18:0] S_ROUT   = 19'd1 << 3;
  localparam logic [18:0] S_BAOUT  = 19'd1 << 2;
  localparam logic [18:0] S_READ   = 19'd1 << 1;
  localparam logic [18:0] S_WRITE  = 19'd1;
  localparam logic [18:0] S_NONE   = 19'd0;

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_LD   = 32'h02100010;
  localparam logic [31:0] I_ST   = 32'h12100010;
  localparam logic [31:0] I_LDI  = 32'h08800005;
  localparam logic [31:0] I_ORI  = 32'h70880005;
  localparam logic [31:0] I_ADDI = 32'h60880005;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL  = 32'hF8000000;

  typedef struct {
    string       nm;
    logic [25:0] v;
  } expT;

  expT q[$];
  int  checks = 0;
  int  errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One driven cycle: apply inputs just after the edge, queue what must be seen.
  task automatic cyc(input logic clr, input logic stp, input logic [31:0] ir,
                     input string nm, input logic [18:0] s, input logic [4:0] alu,
                     input logic rn, input logic il);
    expT e;
    @(posedge clock);
    #1;
    clear = clr;
    stop  = stp;
    IR    = ir;
    e.nm  = nm;
    e.v   = {s, alu, rn, il};
    q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir, input string tag);
    cyc(0, 0, ir, {tag, "_T0"}, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1, 0);
    cyc(0, 0, ir, {tag, "_T1"}, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ALU_ADD, 1, 0);
    cyc(0, 0, ir, {tag, "_T2"}, S_MDROUT | S_IRIN, ALU_ADD, 1, 0);
  endtask

  // Monitor: compare the full output vector and the single-bus-driver rule.
  always @(negedge clock) begin
    logic [25:0] act;
    expT e;
    act = {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout,
           CSignout, Gra, Grb, Grc, Rin, Rout, BAout, read, write,
           aluControl, run, illegal};
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      checks++;
      if ($countones({PCout, MDRout, ZLOout, CSignout, Rout, BAout}) > 1) begin
        errors++;
        $display("FAIL busSource %s: got %0d drivers expected at most 1", e.nm,
                 $countones({PCout, MDRout, ZLOout, CSignout, Rout, BAout}));
      end
    end
  end

  initial begin
    int budget;
    clear = 1'b1;
    stop  = 1'b0;
    IR    = 32'h0;

    cyc(1, 0, I_ADD, "reset", S_NONE, ALU_ADD, 1, 0);

    fetch(I_ADD, "add");
    cyc(0, 0, I_ADD, "add_T3", S_GRB | S_ROUT | S_YIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ADD, "add_T4", S_GRC | S_ROUT | S_ZIN, 5'b00011, 1, 0);
    cyc(0, 0, I_ADD, "add_T5", S_ZLOOUT | S_GRA | S_RIN, ALU_ADD, 1, 0);

    fetch(I_LD, "ld");
    cyc(0, 0, I_LD, "ld_T3", S_GRB | S_BAOUT | S_YIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LD, "ld_T4", S_CSIGN | S_ZIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LD, "ld_T5", S_ZLOOUT | S_MARIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LD, "ld_T6", S_READ | S_MDRIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LD, "ld_T7", S_MDROUT | S_GRA | S_RIN, ALU_ADD, 1, 0);

    fetch(I_ST, "st");
    cyc(0, 0, I_ST, "st_T3", S_GRB | S_BAOUT | S_YIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ST, "st_T4", S_CSIGN | S_ZIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ST, "st_T5", S_ZLOOUT | S_MARIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ST, "st_T6", S_GRA | S_ROUT | S_MDRIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ST, "st_T7", S_WRITE, ALU_ADD, 1, 0);

    fetch(I_LDI, "ldi");
    cyc(0, 0, I_LDI, "ldi_T3", S_GRB | S_BAOUT | S_YIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LDI, "ldi_T4", S_CSIGN | S_ZIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_LDI, "ldi_T5", S_ZLOOUT | S_GRA | S_RIN, ALU_ADD, 1, 0);

    fetch(I_ORI, "ori");
    cyc(0, 0, I_ORI, "ori_T3", S_GRB | S_ROUT | S_YIN, ALU_ADD, 1, 0);
    cyc(0, 0, I_ORI, "ori_T4", S_CSIGN | S_ZIN, ALU_OR, 1, 0);
    cyc(0, 0, I_ORI, "ori_T5", S_ZLOOUT | S_GRA | S_RIN, ALU_ADD, 1, 0);

    fetch(I_ADDI, "addi");
    cyc(0, 0, I_ADDI, "addi_T3", S_GRB | S_ROUT | S_YIN, ALU_ADD, 1, 0);
    cyc(1, 0, I_ADDI, "addi_clrT4", S_NONE, ALU_ADD, 1, 0);

    cyc(0, 1, I_ADD, "stop_T0", S_NONE, ALU_ADD, 1, 0);
    cyc(0, 0, I_ADD, "stop_halt", S_NONE, ALU_ADD, 0, 0);
    cyc(0, 0, I_ADD, "stop_halt2", S_NONE, ALU_ADD, 0, 0);
    cyc(1, 0, I_ADD, "stop_clr", S_NONE, ALU_ADD, 1, 0);

    fetch(I_NOP, "nop");
    cyc(0, 0, I_NOP, "nop_T3", S_NONE, ALU_ADD, 1, 0);

    fetch(I_HALT, "halt");
    cyc(0, 0, I_HALT, "halt_T3", S_NONE, ALU_ADD, 1, 0);
    for (int i = 0; i < 20; i++)
      cyc(0, 0, I_HALT, "halt_hold", S_NONE, ALU_ADD, 0, 0);
    cyc(1, 0, I_HALT, "halt_clr", S_NONE, ALU_ADD, 1, 0);

    fetch(I_ILL, "ill");
    cyc(0, 0, I_ILL, "ill_T3", S_NONE, ALU_ADD, 1, 0);
    cyc(0, 0, I_ILL, "ill_halt", S_NONE, ALU_ADD, 0, 1);
    cyc(0, 1, I_ILL, "ill_halt2", S_NONE, ALU_ADD, 0, 1);
    cyc(1, 0, I_ILL, "ill_clr", S_NONE, ALU_ADD, 1, 0);
    cyc(0, 0, I_ADD, "after_clr_T0", S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1, 0);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
